// File: rtl/pm_loader.sv
// Boot loader for instruction memory: parses a length/word/checksum byte stream,
// writes each assembled word at consecutive addresses, and releases the CPU only on a good checksum.
module pm_loader #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [31:0]       pm_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR
    } state_t;

    state_t            r_state, w_next;
    logic [15:0]       r_count, r_idx;
    logic [7:0]        r_csum;
    logic [1:0]        r_bcnt;
    logic [23:0]       r_word;
    logic              r_byte_ready, r_pm_we, r_cpu_hold, r_done, r_error;
    logic [ADDR_W-1:0] r_pm_addr;
    logic [31:0]       r_pm_wdata;

    logic        w_accept, w_start;
    logic [15:0] w_len, w_idx_inc;

    always_comb begin
        w_accept  = byte_valid && r_byte_ready;
        w_start   = start && (r_state inside {IDLE, DONE, ERR});
        w_len     = {r_count[15:8], byte_in};
        w_idx_inc = r_idx + 16'd1;
        w_next    = r_state;
        case (r_state)
            IDLE, DONE, ERR: if (start) w_next = LEN_HI;
            LEN_HI: if (w_accept) w_next = LEN_LO;
            LEN_LO: if (w_accept) begin
                if (32'(w_len) > MAX_WORDS) w_next = ERR;
                else if (w_len == 16'd0)    w_next = CHECK;
                else                        w_next = DATA;
            end
            DATA:   if (w_accept && r_bcnt == 2'd3) w_next = WRITE;
            WRITE:  w_next = (w_idx_inc == r_count) ? CHECK : DATA;
            CHECK:  if (w_accept) w_next = (byte_in == r_csum) ? DONE : ERR;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_idx        <= '0;
            r_csum       <= '0;
            r_bcnt       <= '0;
            r_word       <= '0;
            r_byte_ready <= 1'b0;
            r_pm_we      <= 1'b0;
            r_pm_addr    <= '0;
            r_pm_wdata   <= '0;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= (w_next inside {LEN_HI, LEN_LO, DATA, CHECK});
            r_pm_we      <= (w_next == WRITE);
            r_done       <= (w_next == DONE);
            r_error      <= (w_next == ERR);
            r_cpu_hold   <= (w_next != DONE);

            if (w_start) begin
                r_csum <= '0;
                r_idx  <= '0;
                r_bcnt <= '0;
            end else if (w_accept) begin
                case (r_state)
                    LEN_HI: begin
                        r_count[15:8] <= byte_in;
                        r_csum        <= r_csum ^ byte_in;
                    end
                    LEN_LO: begin
                        r_count[7:0] <= byte_in;
                        r_csum       <= r_csum ^ byte_in;
                    end
                    DATA: begin
                        r_word <= {r_word[15:0], byte_in};
                        r_bcnt <= r_bcnt + 2'd1;
                        r_csum <= r_csum ^ byte_in;
                    end
                    default: ;
                endcase
            end

            if (w_next == WRITE) begin
                r_pm_addr  <= BASE_ADDR + ADDR_W'(r_idx);
                r_pm_wdata <= {r_word, byte_in};
            end
            if (r_state == WRITE) r_idx <= w_idx_inc;
        end
    end

    assign byte_ready = r_byte_ready;
    assign pm_we      = r_pm_we;
    assign pm_addr    = r_pm_addr;
    assign pm_wdata   = r_pm_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;
    assign error      = r_error;

endmodule
